// File: rtl/rsp_collector_if.sv
// Response-collector bus: dispatcher and engine response inputs, rsp FIFO write ports and feedback.
// Every *_write_en / *_valid qualifies its fields for that one cycle only; there is no ready, and
// backpressure travels only through the almost_full flags.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

interface rsp_collector_if;
    logic                           dsp_alloc_rsp_write_en;
    logic [`REQ_ID_WIDTH-1:0]       dsp_alloc_rsp_id;
    logic [`ALL_PAGE_IDX_WIDTH-1:0] dsp_alloc_rsp_page_idx;
    logic                           dsp_alloc_rsp_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  dsp_alloc_rsp_fail_reason;
    logic                           dsp_free_rsp_write_en;
    logic [`REQ_ID_WIDTH-1:0]       dsp_free_rsp_id;
    logic                           dsp_free_rsp_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  dsp_free_rsp_fail_reason;
    logic                           fdt_alloc_valid;
    logic [`REQ_ID_WIDTH-1:0]       fdt_alloc_id;
    logic [`ALL_PAGE_IDX_WIDTH-1:0] fdt_alloc_page_idx;
    logic                           fdt_alloc_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  fdt_alloc_fail_reason;
    logic                           or_tree_free_valid;
    logic [`REQ_ID_WIDTH-1:0]       or_tree_free_id;
    logic                           or_tree_free_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  or_tree_free_fail_reason;
    logic                           alloc_rsp_write_en;
    logic [`REQ_ID_WIDTH-1:0]       alloc_rsp_id;
    logic [`ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx;
    logic                           alloc_rsp_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason;
    logic                           alloc_rsp_fifo_almost_full;
    logic                           free_rsp_write_en;
    logic [`REQ_ID_WIDTH-1:0]       free_rsp_id;
    logic                           free_rsp_fail;
    logic [`FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason;
    logic                           free_rsp_fifo_almost_full;
    logic                           alloc_rsp_fifo_almost_full_dsp_out;
    logic                           free_rsp_fifo_almost_full_dsp_out;
    logic                           rsp_overflow;

    modport slave (
        input  dsp_alloc_rsp_write_en, dsp_alloc_rsp_id, dsp_alloc_rsp_page_idx,
               dsp_alloc_rsp_fail, dsp_alloc_rsp_fail_reason,
               dsp_free_rsp_write_en, dsp_free_rsp_id, dsp_free_rsp_fail, dsp_free_rsp_fail_reason,
               fdt_alloc_valid, fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_fail_reason,
               or_tree_free_valid, or_tree_free_id, or_tree_free_fail, or_tree_free_fail_reason,
               alloc_rsp_fifo_almost_full, free_rsp_fifo_almost_full,
        output alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
               free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
               alloc_rsp_fifo_almost_full_dsp_out, free_rsp_fifo_almost_full_dsp_out, rsp_overflow
    );

    modport master (
        output dsp_alloc_rsp_write_en, dsp_alloc_rsp_id, dsp_alloc_rsp_page_idx,
               dsp_alloc_rsp_fail, dsp_alloc_rsp_fail_reason,
               dsp_free_rsp_write_en, dsp_free_rsp_id, dsp_free_rsp_fail, dsp_free_rsp_fail_reason,
               fdt_alloc_valid, fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_fail_reason,
               or_tree_free_valid, or_tree_free_id, or_tree_free_fail, or_tree_free_fail_reason,
               alloc_rsp_fifo_almost_full, free_rsp_fifo_almost_full,
        input  alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
               free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
               alloc_rsp_fifo_almost_full_dsp_out, free_rsp_fifo_almost_full_dsp_out, rsp_overflow
    );
endinterface

// File: rtl/rsp_collector.sv
// MMU response collector: merges engine and dispatcher responses into the alloc/free rsp FIFOs.
// Optional RSP_COLLECTOR_STATS_EN adds 16-bit ok/fail counters per channel.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module rsp_collector_chan #(
    parameter int Q_PTR_WIDTH = 2,
    parameter int AF_MARGIN   = 2,
    parameter int EW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          eng_v,
    input  logic [EW-1:0] eng_e,
    input  logic          dsp_v,
    input  logic [EW-1:0] dsp_e,
    input  logic          fifo_af,
    output logic          we,
    output logic [EW-1:0] oe,
    output logic          af_dsp,
    output logic          drop
);
    localparam int Q_DEPTH = 1 << Q_PTR_WIDTH;
    localparam int CW      = Q_PTR_WIDTH + 1;
    localparam logic [Q_PTR_WIDTH-1:0] PTR_ONE  = Q_PTR_WIDTH'(1);
    localparam logic [CW-1:0]          DEPTH_C  = CW'(Q_DEPTH);
    localparam logic [CW-1:0]          AF_LEVEL = CW'(Q_DEPTH - AF_MARGIN);

    logic [EW-1:0]          mem [Q_DEPTH];
    logic [Q_PTR_WIDTH-1:0] wr_ptr, rd_ptr, dsp_slot;
    logic [CW-1:0]          cnt, space, n_acc;
    logic                   pop, acc_eng, acc_dsp;

    // Engine entry wins a single free slot; the dispatcher entry is the one sacrificed.
    always_comb begin
        pop      = (cnt != '0) && !fifo_af;
        space    = DEPTH_C - cnt + CW'(pop);
        acc_eng  = eng_v && (space != '0);
        acc_dsp  = dsp_v && (space > CW'(acc_eng));
        n_acc    = CW'(acc_eng) + CW'(acc_dsp);
        dsp_slot = acc_eng ? wr_ptr + PTR_ONE : wr_ptr;
        drop     = (eng_v && !acc_eng) || (dsp_v && !acc_dsp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            we     <= 1'b0;
            oe     <= '0;
            af_dsp <= 1'b0;
        end else begin
            if (acc_eng) mem[wr_ptr] <= eng_e;
            if (acc_dsp) mem[dsp_slot] <= dsp_e;
            wr_ptr <= wr_ptr + n_acc[Q_PTR_WIDTH-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                oe     <= mem[rd_ptr];
            end
            we     <= pop;
            cnt    <= cnt + n_acc - CW'(pop);
            af_dsp <= fifo_af || (cnt >= AF_LEVEL);
        end
    end
endmodule

module rsp_collector #(
    parameter int Q_PTR_WIDTH = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rsp_collector_if.slave   bus
`ifdef RSP_COLLECTOR_STATS_EN
    ,
    output logic [15:0]      stat_alloc_ok,
    output logic [15:0]      stat_alloc_fail,
    output logic [15:0]      stat_free_ok,
    output logic [15:0]      stat_free_fail
`endif
);
    localparam int IW   = `REQ_ID_WIDTH;
    localparam int PW   = `ALL_PAGE_IDX_WIDTH;
    localparam int RW   = `FAIL_REASON_WIDTH;
    localparam int A_EW = IW + PW + 1 + RW;
    localparam int F_EW = IW + 1 + RW;

    logic            alloc_we, free_we, alloc_drop, free_drop, overflow;
    logic [A_EW-1:0] alloc_oe;
    logic [F_EW-1:0] free_oe;

    rsp_collector_chan #(.Q_PTR_WIDTH(Q_PTR_WIDTH), .AF_MARGIN(AF_MARGIN), .EW(A_EW)) u_alloc (
        .clk     (clk),
        .rst_n   (rst_n),
        .eng_v   (bus.fdt_alloc_valid),
        .eng_e   ({bus.fdt_alloc_id, bus.fdt_alloc_page_idx, bus.fdt_alloc_fail, bus.fdt_alloc_fail_reason}),
        .dsp_v   (bus.dsp_alloc_rsp_write_en),
        .dsp_e   ({bus.dsp_alloc_rsp_id, bus.dsp_alloc_rsp_page_idx, bus.dsp_alloc_rsp_fail,
                   bus.dsp_alloc_rsp_fail_reason}),
        .fifo_af (bus.alloc_rsp_fifo_almost_full),
        .we      (alloc_we),
        .oe      (alloc_oe),
        .af_dsp  (bus.alloc_rsp_fifo_almost_full_dsp_out),
        .drop    (alloc_drop)
    );

    rsp_collector_chan #(.Q_PTR_WIDTH(Q_PTR_WIDTH), .AF_MARGIN(AF_MARGIN), .EW(F_EW)) u_free (
        .clk     (clk),
        .rst_n   (rst_n),
        .eng_v   (bus.or_tree_free_valid),
        .eng_e   ({bus.or_tree_free_id, bus.or_tree_free_fail, bus.or_tree_free_fail_reason}),
        .dsp_v   (bus.dsp_free_rsp_write_en),
        .dsp_e   ({bus.dsp_free_rsp_id, bus.dsp_free_rsp_fail, bus.dsp_free_rsp_fail_reason}),
        .fifo_af (bus.free_rsp_fifo_almost_full),
        .we      (free_we),
        .oe      (free_oe),
        .af_dsp  (bus.free_rsp_fifo_almost_full_dsp_out),
        .drop    (free_drop)
    );

    assign bus.alloc_rsp_write_en = alloc_we;
    assign {bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail, bus.alloc_rsp_fail_reason} = alloc_oe;
    assign bus.free_rsp_write_en  = free_we;
    assign {bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason} = free_oe;
    assign bus.rsp_overflow       = overflow;

    always_ff @(posedge clk) begin
        if (!rst_n)                       overflow <= 1'b0;
        else if (alloc_drop || free_drop) overflow <= 1'b1;
    end

`ifdef RSP_COLLECTOR_STATS_EN
    // Counted off the registered write port so the stats match what the FIFOs actually received.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_alloc_ok   <= '0;
            stat_alloc_fail <= '0;
            stat_free_ok    <= '0;
            stat_free_fail  <= '0;
        end else begin
            if (alloc_we &&  alloc_oe[RW]) stat_alloc_fail <= stat_alloc_fail + 16'd1;
            if (alloc_we && !alloc_oe[RW]) stat_alloc_ok   <= stat_alloc_ok + 16'd1;
            if (free_we  &&  free_oe[RW])  stat_free_fail  <= stat_free_fail + 16'd1;
            if (free_we  && !free_oe[RW])  stat_free_ok    <= stat_free_ok + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rsp_collector.sv
// Directed bench for rsp_collector: latency, collision order, overflow, full-with-pop, reset flush.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module tb_rsp_collector;
    localparam int IW = `REQ_ID_WIDTH;
    localparam int PW = `ALL_PAGE_IDX_WIDTH;
    localparam int RW = `FAIL_REASON_WIDTH;
    localparam logic [RW-1:0] EQUAL_ZERO = RW'(1);

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rsp_collector_if bus ();
`ifdef RSP_COLLECTOR_STATS_EN
    logic [15:0] stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail;
`endif

    rsp_collector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus)
`ifdef RSP_COLLECTOR_STATS_EN
        ,
        .stat_alloc_ok   (stat_alloc_ok),
        .stat_alloc_fail (stat_alloc_fail),
        .stat_free_ok    (stat_free_ok),
        .stat_free_fail  (stat_free_fail)
`endif
    );

    // scoreboard
    logic [31:0] alloc_exp_q[$];
    logic [31:0] free_exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.alloc_rsp_write_en === 1'b1) begin
            if (alloc_exp_q.size() == 0) check_eq("alloc_unexpected_write", 32'(bus.alloc_rsp_write_en), 32'd0);
            else check_eq("alloc_entry", 32'({bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail,
                                              bus.alloc_rsp_fail_reason}), alloc_exp_q.pop_front());
        end
        if (bus.free_rsp_write_en === 1'b1) begin
            if (free_exp_q.size() == 0) check_eq("free_unexpected_write", 32'(bus.free_rsp_write_en), 32'd0);
            else check_eq("free_entry", 32'({bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}),
                          free_exp_q.pop_front());
        end
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dsp_alloc_rsp_write_en = 1'b0; bus.dsp_alloc_rsp_id = '0; bus.dsp_alloc_rsp_page_idx = '0;
        bus.dsp_alloc_rsp_fail = 1'b0; bus.dsp_alloc_rsp_fail_reason = '0;
        bus.dsp_free_rsp_write_en = 1'b0; bus.dsp_free_rsp_id = '0;
        bus.dsp_free_rsp_fail = 1'b0; bus.dsp_free_rsp_fail_reason = '0;
        bus.fdt_alloc_valid = 1'b0; bus.fdt_alloc_id = '0; bus.fdt_alloc_page_idx = '0;
        bus.fdt_alloc_fail = 1'b0; bus.fdt_alloc_fail_reason = '0;
        bus.or_tree_free_valid = 1'b0; bus.or_tree_free_id = '0;
        bus.or_tree_free_fail = 1'b0; bus.or_tree_free_fail_reason = '0;
    endtask

    task automatic set_fdt(input logic [IW-1:0] id, input logic [PW-1:0] pg, input logic f,
                           input logic [RW-1:0] r, input bit expect_it);
        bus.fdt_alloc_valid = 1'b1; bus.fdt_alloc_id = id; bus.fdt_alloc_page_idx = pg;
        bus.fdt_alloc_fail = f; bus.fdt_alloc_fail_reason = r;
        if (expect_it) alloc_exp_q.push_back(32'({id, pg, f, r}));
    endtask

    task automatic set_dsp_alloc(input logic [IW-1:0] id, input logic [PW-1:0] pg, input logic f,
                                 input logic [RW-1:0] r, input bit expect_it);
        bus.dsp_alloc_rsp_write_en = 1'b1; bus.dsp_alloc_rsp_id = id; bus.dsp_alloc_rsp_page_idx = pg;
        bus.dsp_alloc_rsp_fail = f; bus.dsp_alloc_rsp_fail_reason = r;
        if (expect_it) alloc_exp_q.push_back(32'({id, pg, f, r}));
    endtask

    task automatic set_or_tree(input logic [IW-1:0] id, input logic f, input logic [RW-1:0] r,
                               input bit expect_it);
        bus.or_tree_free_valid = 1'b1; bus.or_tree_free_id = id;
        bus.or_tree_free_fail = f; bus.or_tree_free_fail_reason = r;
        if (expect_it) free_exp_q.push_back(32'({id, f, r}));
    endtask

    task automatic set_dsp_free(input logic [IW-1:0] id, input logic f, input logic [RW-1:0] r,
                                input bit expect_it);
        bus.dsp_free_rsp_write_en = 1'b1; bus.dsp_free_rsp_id = id;
        bus.dsp_free_rsp_fail = f; bus.dsp_free_rsp_fail_reason = r;
        if (expect_it) free_exp_q.push_back(32'({id, f, r}));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((alloc_exp_q.size() != 0 || free_exp_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(alloc_exp_q.size() + free_exp_q.size()), 32'd0);
    endtask

    initial begin
        clear_inputs();
        bus.alloc_rsp_fifo_almost_full = 1'b0;
        bus.free_rsp_fifo_almost_full  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_alloc_we",   32'(bus.alloc_rsp_write_en), 32'd0);
        check_eq("rst_free_we",    32'(bus.free_rsp_write_en), 32'd0);
        check_eq("rst_alloc_data", 32'({bus.alloc_rsp_id, bus.alloc_rsp_page_idx, bus.alloc_rsp_fail}), 32'd0);
        check_eq("rst_free_data",  32'({bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}), 32'd0);
        check_eq("rst_af_out",     32'({bus.alloc_rsp_fifo_almost_full_dsp_out,
                                        bus.free_rsp_fifo_almost_full_dsp_out}), 32'd0);
        check_eq("rst_overflow",   32'(bus.rsp_overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // single fdt response: write_en two cycles after the valid
        set_fdt(8'd5, 8'h40, 1'b0, 2'd0, 1'b1);
        tick();
        clear_inputs();
        check_eq("t1_we_n1", 32'(bus.alloc_rsp_write_en), 32'd0);
        tick();
        check_eq("t1_we_n2", 32'(bus.alloc_rsp_write_en), 32'd1);
        check_eq("t1_id",    32'(bus.alloc_rsp_id), 32'd5);
        check_eq("t1_page",  32'(bus.alloc_rsp_page_idx), 32'h40);
        check_eq("t1_fail",  32'(bus.alloc_rsp_fail), 32'd0);
        tick();
        check_eq("t1_we_n3", 32'(bus.alloc_rsp_write_en), 32'd0);
        drain("t1");

        // collision on free channel: engine first, dispatcher next cycle
        set_or_tree(8'd3, 1'b0, 2'd0, 1'b1);
        set_dsp_free(8'd7, 1'b1, EQUAL_ZERO, 1'b1);
        tick();
        clear_inputs();
        tick();
        check_eq("t2_first_we", 32'(bus.free_rsp_write_en), 32'd1);
        check_eq("t2_first_id", 32'(bus.free_rsp_id), 32'd3);
        tick();
        check_eq("t2_second_we", 32'(bus.free_rsp_write_en), 32'd1);
        check_eq("t2_second", 32'({bus.free_rsp_id, bus.free_rsp_fail, bus.free_rsp_fail_reason}),
                 32'({8'd7, 1'b1, EQUAL_ZERO}));
        tick();
        check_eq("t2_after_we", 32'(bus.free_rsp_write_en), 32'd0);
        check_eq("t2_no_overflow", 32'(bus.rsp_overflow), 32'd0);
        drain("t2");

        // six responses into a stalled free channel: four kept, two dropped
        bus.free_rsp_fifo_almost_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_or_tree(8'(10 + i), 1'b0, 2'd0, i < 4);
            tick();
        end
        clear_inputs();
        check_eq("t3_stalled_we", 32'(bus.free_rsp_write_en), 32'd0);
        check_eq("t3_overflow",   32'(bus.rsp_overflow), 32'd1);
        check_eq("t3_free_af",    32'(bus.free_rsp_fifo_almost_full_dsp_out), 32'd1);
        check_eq("t3_alloc_af",   32'(bus.alloc_rsp_fifo_almost_full_dsp_out), 32'd0);
        bus.free_rsp_fifo_almost_full = 1'b0;
        drain("t3");
        repeat (2) tick();
        check_eq("t3_free_af_clear", 32'(bus.free_rsp_fifo_almost_full_dsp_out), 32'd0);

        // full alloc queue, pop active, two incoming: engine kept, dispatcher dropped
        pulse_reset();
        check_eq("t4_overflow_cleared", 32'(bus.rsp_overflow), 32'd0);
        bus.alloc_rsp_fifo_almost_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_fdt(8'(20 + i), 8'(16 + i), 1'b0, 2'd0, 1'b1);
            tick();
        end
        clear_inputs();
        check_eq("t4_full_no_overflow", 32'(bus.rsp_overflow), 32'd0);
        bus.alloc_rsp_fifo_almost_full = 1'b0;
        set_fdt(8'd24, 8'd20, 1'b0, 2'd0, 1'b1);
        set_dsp_alloc(8'd25, 8'd0, 1'b1, 2'd2, 1'b0);
        tick();
        clear_inputs();
        check_eq("t4_overflow", 32'(bus.rsp_overflow), 32'd1);
        check_eq("t4_head_we",  32'(bus.alloc_rsp_write_en), 32'd1);
        check_eq("t4_head_id",  32'(bus.alloc_rsp_id), 32'd20);
        tick();
        check_eq("t4_af_from_count", 32'(bus.alloc_rsp_fifo_almost_full_dsp_out), 32'd1);
        drain("t4");
        repeat (2) tick();
        check_eq("t4_idle_we", 32'(bus.alloc_rsp_write_en), 32'd0);
        check_eq("t4_af_clear", 32'(bus.alloc_rsp_fifo_almost_full_dsp_out), 32'd0);

        // reset with three pending free entries flushes them
        bus.free_rsp_fifo_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_or_tree(8'(40 + i), 1'b0, 2'd0, 1'b0);
            tick();
        end
        clear_inputs();
        pulse_reset();
        bus.free_rsp_fifo_almost_full = 1'b0;
        check_eq("t5_overflow_cleared", 32'(bus.rsp_overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t5_no_write", 32'(bus.free_rsp_write_en), 32'd0);
        end
        check_eq("t5_af_count0", 32'(bus.free_rsp_fifo_almost_full_dsp_out), 32'd0);

`ifdef RSP_COLLECTOR_STATS_EN
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            set_fdt(8'(30 + i), 8'(i), 1'b0, 2'd0, 1'b1);
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            set_dsp_alloc(8'(33 + i), 8'd0, 1'b1, 2'd1, 1'b1);
            tick();
        end
        clear_inputs();
        set_dsp_free(8'd35, 1'b1, EQUAL_ZERO, 1'b1);
        tick();
        clear_inputs();
        drain("stats");
        repeat (2) tick();
        check_eq("stat_alloc_ok",   32'(stat_alloc_ok), 32'd3);
        check_eq("stat_alloc_fail", 32'(stat_alloc_fail), 32'd2);
        check_eq("stat_free_ok",    32'(stat_free_ok), 32'd0);
        check_eq("stat_free_fail",  32'(stat_free_fail), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
